// File: rtl/mul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul_seq_ctrl
//   Sequencer for the iterative 64-bit multiplier in the EX stage. It detects
//   a MUL in EX (mush code 2'b10), issues a start strobe, steps the
//   multiplier STEPS times, and then presents the product. IF/ID/EX are
//   stalled until the product is ready. A branch flush aborts the sequence,
//   and a downstream hold keeps the product presented. Two saturating
//   performance counters track completed MULs and MUL stall cycles.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        asynchronous reset, active-low (0 = reset)
//   i_ex_valid     EX stage holds a live instruction
//   i_ex_mush      decoder mush code of the EX instruction (2'b10 = MUL)
//   i_flush        branch taken: kill IF/ID/EX contents this cycle
//   i_hold_in      downstream (MEM/WB) stall
//   o_stall        freeze PC, IF/ID and ID/EX
//   o_mul_start    load operands into the multiplier, clear the accumulator
//   o_mul_step     advance the multiplier one step
//   o_mul_done     product valid for EX/MEM capture
//   o_busy         sequencer is not idle
//   o_step_cnt     remaining multiplier steps (debug)
//   o_mul_total    completed MULs, saturating
//   o_stall_total  cycles this block asserted stall, saturating
// ---------------------------------------------------------------------------
module mul_seq_ctrl #(
  parameter int STEPS = 8,
  parameter int CNT_W = 32
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_ex_valid,
  input  logic [1:0]                   i_ex_mush,
  input  logic                         i_flush,
  input  logic                         i_hold_in,
  output logic                         o_stall,
  output logic                         o_mul_start,
  output logic                         o_mul_step,
  output logic                         o_mul_done,
  output logic                         o_busy,
  output logic [$clog2(STEPS+1)-1:0]   o_step_cnt,
  output logic [CNT_W-1:0]             o_mul_total,
  output logic [CNT_W-1:0]             o_stall_total
);

  localparam int CW = $clog2(STEPS+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_step_cnt;
  logic [CNT_W-1:0]  r_mul_total;
  logic [CNT_W-1:0]  r_stall_total;

  logic              w_is_mul;
  logic              w_stall;
  logic              w_start;
  logic              w_step;
  logic              w_done;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_is_mul = i_ex_valid & (i_ex_mush == 2'b10);

  // Strobes are decoded from the registered state combined with the current
  // inputs: the pipeline must see the stall in the same cycle the MUL enters
  // EX, and a flush must drop every strobe in the cycle it occurs. Gating
  // with i_reset keeps every output at 0 while reset is held, even though
  // the inputs may still show a MUL.
  always_comb begin
    w_stall = 1'b0;
    w_start = 1'b0;
    w_step  = 1'b0;
    w_done  = 1'b0;
    if (i_reset && !i_flush) begin
      case (r_state)
        S_IDLE: begin
          w_start = w_is_mul;
          w_stall = w_is_mul;
        end
        S_RUN: begin
          w_step  = 1'b1;
          w_stall = 1'b1;
        end
        S_DONE: begin
          w_done  = 1'b1;
          w_stall = i_hold_in;
        end
        default: ;
      endcase
    end
  end

  assign o_stall       = w_stall;
  assign o_mul_start   = w_start;
  assign o_mul_step    = w_step;
  assign o_mul_done    = w_done;
  assign o_busy        = i_reset & (r_state != S_IDLE);
  assign o_step_cnt    = i_reset ? r_step_cnt    : '0;
  assign o_mul_total   = i_reset ? r_mul_total   : '0;
  assign o_stall_total = i_reset ? r_stall_total : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_step_cnt    <= '0;
      r_mul_total   <= '0;
      r_stall_total <= '0;
    end else begin
      if (w_stall)
        r_stall_total <= sat_inc(r_stall_total);

      if (i_flush) begin
        // Aborted MUL: back to idle, nothing counted as completed.
        r_state    <= S_IDLE;
        r_step_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_is_mul) begin
              r_state    <= S_RUN;
              r_step_cnt <= CW'(STEPS);
            end
          end
          S_RUN: begin
            r_step_cnt <= r_step_cnt - CW'(1);
            // Leaving on the last step gives exactly STEPS step cycles.
            if (r_step_cnt == CW'(1))
              r_state <= S_DONE;
          end
          S_DONE: begin
            // EX still holds the finished MUL here, so mush is ignored.
            if (!i_hold_in) begin
              r_state     <= S_IDLE;
              r_mul_total <= sat_inc(r_mul_total);
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_step_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_ex_valid = 1'b0;
  logic [1:0]  i_ex_mush = 2'b00;
  logic        i_flush = 1'b0;
  logic        i_hold_in = 1'b0;

  logic        o_stall, o_mul_start, o_mul_step, o_mul_done, o_busy;
  logic [3:0]  o_step_cnt;
  logic [31:0] o_mul_total, o_stall_total;

  logic        d2_stall, d2_start, d2_step, d2_done, d2_busy;
  logic [0:0]  d2_step_cnt;
  logic [3:0]  d2_mul_total, d2_stall_total;

  int n_run  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  mul_seq_ctrl #(.STEPS(8), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ex_valid(i_ex_valid),
    .i_ex_mush(i_ex_mush), .i_flush(i_flush), .i_hold_in(i_hold_in),
    .o_stall(o_stall), .o_mul_start(o_mul_start), .o_mul_step(o_mul_step),
    .o_mul_done(o_mul_done), .o_busy(o_busy), .o_step_cnt(o_step_cnt),
    .o_mul_total(o_mul_total), .o_stall_total(o_stall_total)
  );

  // Single-step, narrow-counter instance for the STEPS=1 and saturation edges.
  mul_seq_ctrl #(.STEPS(1), .CNT_W(4)) dut2 (
    .i_clk(i_clk), .i_reset(i_reset), .i_ex_valid(i_ex_valid),
    .i_ex_mush(i_ex_mush), .i_flush(i_flush), .i_hold_in(i_hold_in),
    .o_stall(d2_stall), .o_mul_start(d2_start), .o_mul_step(d2_step),
    .o_mul_done(d2_done), .o_busy(d2_busy), .o_step_cnt(d2_step_cnt),
    .o_mul_total(d2_mul_total), .o_stall_total(d2_stall_total)
  );

  typedef struct {
    logic       v;
    logic [1:0] m;
    logic       f;
    logic       h;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  // {stall, start, step, done, busy, step_cnt}
  function automatic logic [8:0] pk(input logic s, input logic st, input logic sp,
                                    input logic d, input logic b, input int c);
    logic [3:0] c4;
    c4 = 4'(c);
    return {s, st, sp, d, b, c4};
  endfunction

  function automatic logic [8:0] outs();
    return {o_stall, o_mul_start, o_mul_step, o_mul_done, o_busy, o_step_cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are applied just after a rising edge, outputs compared on the
  // falling edge, then time advances to just past the next rising edge.
  task automatic cyc(input string name, input logic v, input logic [1:0] m,
                     input logic f, input logic h, input logic [8:0] exp);
    i_ex_valid = v; i_ex_mush = m; i_flush = f; i_hold_in = h;
    @(negedge i_clk);
    chk(name, 32'(outs()), 32'(exp));
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_ex_valid = 1'b0; i_ex_mush = 2'b00; i_flush = 1'b0; i_hold_in = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail + 1);
    $fatal(1);
  end

  initial begin
    // ---------------- reset state, with a MUL on the inputs ----------------
    i_reset = 1'b0; i_ex_valid = 1'b1; i_ex_mush = 2'b10;
    #12;
    chk("reset_outs", 32'(outs()), 32'(pk(0,0,0,0,0,0)));
    chk("reset_mul_total", o_mul_total, 0);
    chk("reset_stall_total", o_stall_total, 0);
    chk("reset_dut2_outs", 32'({d2_stall, d2_start, d2_step, d2_done, d2_busy}), 0);
    do_reset();

    // ---------------- table: non-MUL traffic, then one plain MUL -----------
    tbl.push_back('{1'b1, 2'b00, 1'b0, 1'b0, pk(0,0,0,0,0,0)});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 1'b0, pk(0,0,0,0,0,0)});
    tbl.push_back('{1'b1, 2'b11, 1'b0, 1'b0, pk(0,0,0,0,0,0)});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 1'b0, pk(0,0,0,0,0,0)});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 1'b1, pk(0,0,0,0,0,0)});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 1'b0, pk(1,1,0,0,0,0)});
    for (int k = 8; k >= 1; k--)
      tbl.push_back('{1'b1, 2'b10, 1'b0, 1'b0, pk(1,0,1,0,1,k)});
    tbl.push_back('{1'b1, 2'b00, 1'b0, 1'b0, pk(0,0,0,1,1,0)});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 1'b0, pk(0,0,0,0,0,0)});
    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].m, tbl[i].f, tbl[i].h, tbl[i].exp);
    chk("single_mul_total", o_mul_total, 1);
    chk("single_stall_total", o_stall_total, 9);

    // ---------------- back-to-back MULs ----------------
    do_reset();
    for (int k = 0; k < 20; k++) begin
      int p;
      p = k % 10;
      if (p == 0)      cyc($sformatf("b2b[%0d]", k), 1, 2'b10, 0, 0, pk(1,1,0,0,0,0));
      else if (p < 9)  cyc($sformatf("b2b[%0d]", k), 1, 2'b10, 0, 0, pk(1,0,1,0,1,9-p));
      else             cyc($sformatf("b2b[%0d]", k), 1, 2'b10, 0, 0, pk(0,0,0,1,1,0));
    end
    cyc("b2b_idle", 0, 2'b00, 0, 0, pk(0,0,0,0,0,0));
    chk("b2b_mul_total", o_mul_total, 2);
    chk("b2b_stall_total", o_stall_total, 18);

    // ---------------- flush on the third RUN cycle ----------------
    do_reset();
    cyc("fl_start", 1, 2'b10, 0, 0, pk(1,1,0,0,0,0));
    cyc("fl_run8",  1, 2'b10, 0, 0, pk(1,0,1,0,1,8));
    cyc("fl_run7",  1, 2'b10, 0, 0, pk(1,0,1,0,1,7));
    cyc("fl_flush", 1, 2'b10, 1, 0, pk(0,0,0,0,1,6));
    for (int k = 0; k < 10; k++)
      cyc($sformatf("fl_idle[%0d]", k), 0, 2'b00, 0, 0, pk(0,0,0,0,0,0));
    chk("fl_mul_total", o_mul_total, 0);
    chk("fl_stall_total", o_stall_total, 3);

    // ---------------- flush while a MUL arrives in IDLE ----------------
    cyc("fl_idle_mul", 1, 2'b10, 1, 0, pk(0,0,0,0,0,0));
    cyc("fl_idle_after", 0, 2'b00, 0, 0, pk(0,0,0,0,0,0));

    // ---------------- downstream hold at DONE ----------------
    do_reset();
    cyc("hd_start", 1, 2'b10, 0, 0, pk(1,1,0,0,0,0));
    for (int k = 8; k >= 1; k--)
      cyc($sformatf("hd_run%0d", k), 1, 2'b10, 0, 1, pk(1,0,1,0,1,k));
    cyc("hd_done_h1", 1, 2'b10, 0, 1, pk(1,0,0,1,1,0));
    chk("hd_mul_total_held", o_mul_total, 0);
    cyc("hd_done_h2", 1, 2'b10, 0, 1, pk(1,0,0,1,1,0));
    cyc("hd_done_go", 1, 2'b10, 0, 0, pk(0,0,0,1,1,0));
    cyc("hd_idle", 0, 2'b00, 0, 0, pk(0,0,0,0,0,0));
    chk("hd_mul_total", o_mul_total, 1);
    chk("hd_stall_total", o_stall_total, 11);

    // ---------------- asynchronous reset mid-RUN ----------------
    do_reset();
    cyc("rs_start", 1, 2'b10, 0, 0, pk(1,1,0,0,0,0));
    cyc("rs_run8",  1, 2'b10, 0, 0, pk(1,0,1,0,1,8));
    cyc("rs_run7",  1, 2'b10, 0, 0, pk(1,0,1,0,1,7));
    cyc("rs_run6",  1, 2'b10, 0, 0, pk(1,0,1,0,1,6));
    chk("rs_step_cnt_pre", 32'(o_step_cnt), 5);
    chk("rs_stall_total_pre", o_stall_total, 4);
    i_reset = 1'b0;
    #1;
    chk("rs_outs_now", 32'(outs()), 32'(pk(0,0,0,0,0,0)));
    chk("rs_stall_total_now", o_stall_total, 0);
    @(negedge i_clk);
    chk("rs_outs_held", 32'(outs()), 32'(pk(0,0,0,0,0,0)));
    @(posedge i_clk); #1;
    i_ex_valid = 1'b0; i_ex_mush = 2'b00;
    i_reset = 1'b1;
    cyc("rs_idle", 0, 2'b00, 0, 0, pk(0,0,0,0,0,0));
    chk("rs_mul_total", o_mul_total, 0);
    chk("rs_stall_total", o_stall_total, 0);
    cyc("rs_restart", 1, 2'b10, 0, 0, pk(1,1,0,0,0,0));
    cyc("rs_restart_run", 0, 2'b00, 0, 0, pk(1,0,1,0,1,8));

    // ---------------- STEPS=1 sequence and counter saturation ----------------
    do_reset();
    i_ex_valid = 1'b1; i_ex_mush = 2'b10;
    for (int k = 0; k < 60; k++) begin
      if (k < 3) begin
        @(negedge i_clk);
        if (k == 0) chk("s1_start", 32'({d2_stall, d2_start, d2_step, d2_done, d2_busy, d2_step_cnt}), 32'(6'b110000));
        if (k == 1) chk("s1_step",  32'({d2_stall, d2_start, d2_step, d2_done, d2_busy, d2_step_cnt}), 32'(6'b101011));
        if (k == 2) chk("s1_done",  32'({d2_stall, d2_start, d2_step, d2_done, d2_busy, d2_step_cnt}), 32'(6'b000110));
      end
      @(posedge i_clk); #1;
      if (k == 11) begin
        chk("s1_mul_total_4", 32'(d2_mul_total), 4);
        chk("s1_stall_total_8", 32'(d2_stall_total), 8);
      end
    end
    chk("sat_mul_total", 32'(d2_mul_total), 15);
    chk("sat_stall_total", 32'(d2_stall_total), 15);
    i_ex_valid = 1'b0; i_ex_mush = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
